// File: rtl/dsm_dac_sample_scheduler.sv
// dsm_dac_sample_scheduler
// Rate-adapting front end for the first-order delta-sigma DAC stage.
// PCM samples arrive on an AXI-Stream slave and are buffered in a small FIFO.
// Each sample is held on the modulator port for osr_q accepted ticks.
// Underrun either repeats the last sample or outputs zero.

module dsm_dac_sample_scheduler #(
    parameter int WIDTH      = 16,
    parameter int OSR_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          aclk,
    input  logic                          arst_n,
    input  logic                          cfg_enable,
    input  logic [OSR_W-1:0]              cfg_osr,
    input  logic                          cfg_underrun_mute,
    input  logic [WIDTH-1:0]              s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [WIDTH-1:0]              m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          stat_underrun,
    output logic [$clog2(FIFO_DEPTH):0]   stat_fifo_level,
    output logic [15:0]                   stat_sample_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_RUN,
        S_UNDERRUN
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic [OSR_W-1:0] r_cnt;
    logic [OSR_W-1:0] r_osr_q;
    logic [WIDTH-1:0] r_hold;
    logic [WIDTH-1:0] r_tdata;
    logic             r_tvalid;
    logic             r_underrun;
    logic [15:0]      r_sample_cnt;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_accept;
    logic             w_last;
    logic             w_period_end;
    logic             w_load;
    logic [WIDTH-1:0] w_head;
    logic [OSR_W-1:0] w_osr_eff;

    assign w_full       = (r_level == FULL_LEVEL);
    assign w_empty      = (r_level == '0);
    assign w_push       = s_axis_tvalid && s_axis_tready;
    assign w_accept     = r_tvalid && m_axis_tready;
    assign w_last       = (r_cnt == (r_osr_q - OSR_W'(1)));
    assign w_period_end = w_accept && w_last;
    assign w_head       = r_mem[r_rptr];
    assign w_osr_eff    = (cfg_osr == '0) ? OSR_W'(1) : cfg_osr;

    // A load pops the FIFO head; it happens when priming, or at a period
    // boundary in RUN/UNDERRUN, and only when a sample is already buffered.
    assign w_load = cfg_enable && !w_empty &&
                    ((r_state == S_PRIME) ||
                     (((r_state == S_RUN) || (r_state == S_UNDERRUN)) && w_period_end));

    assign s_axis_tready   = cfg_enable && !w_full;
    assign m_axis_tdata    = r_tdata;
    assign m_axis_tvalid   = r_tvalid;
    assign stat_underrun   = r_underrun;
    assign stat_fifo_level = r_level;
    assign stat_sample_cnt = r_sample_cnt;

    // FIFO storage; contents need no reset since level gates every read
    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_mem[r_wptr] <= s_axis_tdata;
        end
    end

    // FIFO pointers and occupancy; disabling flushes the buffer
    always_ff @(posedge aclk) begin
        if (!arst_n || !cfg_enable) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_load) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_level <= r_level + LW'(w_push) - LW'(w_load);
        end
    end

    // Sequencer FSM with registered modulator outputs and status
    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_osr_q      <= OSR_W'(1);
            r_hold       <= '0;
            r_tdata      <= '0;
            r_tvalid     <= 1'b0;
            r_underrun   <= 1'b0;
            r_sample_cnt <= '0;
        end else begin
            r_underrun <= 1'b0;
            if (!cfg_enable) begin
                r_state  <= S_IDLE;
                r_cnt    <= '0;
                r_hold   <= '0;
                r_tdata  <= '0;
                r_tvalid <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_PRIME;
                    end
                    S_PRIME: begin
                        // waits for w_load, handled below
                    end
                    S_RUN: begin
                        if (w_accept) begin
                            if (!w_last) begin
                                r_cnt <= r_cnt + OSR_W'(1);
                            end else if (w_empty) begin
                                r_state    <= S_UNDERRUN;
                                r_cnt      <= '0;
                                r_underrun <= 1'b1;
                                r_tdata    <= cfg_underrun_mute ? '0 : r_hold;
                            end
                        end
                    end
                    S_UNDERRUN: begin
                        r_tdata <= cfg_underrun_mute ? '0 : r_hold;
                        if (w_accept) begin
                            if (!w_last) begin
                                r_cnt <= r_cnt + OSR_W'(1);
                            end else begin
                                r_cnt <= '0;
                            end
                        end
                    end
                endcase
                // Load overrides the per-state updates above (last NBA wins)
                if (w_load) begin
                    r_hold       <= w_head;
                    r_osr_q      <= w_osr_eff;
                    r_cnt        <= '0;
                    r_sample_cnt <= r_sample_cnt + 16'd1;
                    r_state      <= S_RUN;
                    r_tvalid     <= 1'b1;
                    r_tdata      <= w_head;
                end
            end
        end
    end

endmodule

// File: tb/tb_dsm_dac_sample_scheduler.sv
// Testbench for dsm_dac_sample_scheduler: directed scenarios plus random
// stimulus, checked against a sample-queue reference model and a tick scoreboard.

module tb_dsm_dac_sample_scheduler;

    localparam int WIDTH = 16;
    localparam int OSR_W = 8;
    localparam int DEPTH = 4;

    logic              aclk = 1'b0;
    logic              arst_n;
    logic              cfg_enable;
    logic [OSR_W-1:0]  cfg_osr;
    logic              cfg_underrun_mute;
    logic [WIDTH-1:0]  s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [WIDTH-1:0]  m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              stat_underrun;
    logic [2:0]        stat_fifo_level;
    logic [15:0]       stat_sample_cnt;

    dsm_dac_sample_scheduler #(
        .WIDTH(WIDTH),
        .OSR_W(OSR_W),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .aclk(aclk),
        .arst_n(arst_n),
        .cfg_enable(cfg_enable),
        .cfg_osr(cfg_osr),
        .cfg_underrun_mute(cfg_underrun_mute),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .stat_underrun(stat_underrun),
        .stat_fifo_level(stat_fifo_level),
        .stat_sample_cnt(stat_sample_cnt)
    );

    always #5 aclk = ~aclk;

    // Reference model: buffered samples, what is playing, ticks left in period
    typedef enum int {M_OFF, M_WAIT, M_PLAY, M_STARVED} mode_t;
    mode_t        mode;
    logic [15:0]  mq[$];
    logic [15:0]  m_cur;
    logic [15:0]  m_data;
    logic [15:0]  m_cnt;
    int           m_period;
    int           m_left;
    logic         m_valid;
    logic         m_und;

    logic [15:0]  exp_q[$];
    int           total = 0;
    int           bad = 0;
    bit           mon_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, exp);
        end
    endtask

    // Advance one clock: predict what the edge does to the model, then commit
    task automatic step();
        logic [15:0] nq[$];
        mode_t       nmode;
        int          nperiod;
        int          nleft;
        logic [15:0] ncur;
        logic [15:0] ncnt;
        logic [15:0] ndata;
        logic        nvalid;
        logic        nund;
        bit          load;
        nq = mq;
        nmode = mode;
        nperiod = m_period;
        nleft = m_left;
        ncur = m_cur;
        ncnt = m_cnt;
        nund = 1'b0;
        load = 1'b0;
        if (m_valid && m_axis_tready) exp_q.push_back(m_data);
        if (!arst_n) begin
            nq.delete();
            nmode = M_OFF;
            nperiod = 1;
            nleft = 0;
            ncur = '0;
            ncnt = '0;
        end else if (!cfg_enable) begin
            nq.delete();
            nmode = M_OFF;
            nleft = 0;
            ncur = '0;
        end else begin
            case (mode)
                M_OFF:  nmode = M_WAIT;
                M_WAIT: load = (mq.size() > 0);
                default: begin
                    if (m_axis_tready) begin
                        nleft = m_left - 1;
                        if (nleft == 0) begin
                            if (mq.size() > 0) begin
                                load = 1'b1;
                            end else begin
                                if (mode == M_PLAY) nund = 1'b1;
                                nmode = M_STARVED;
                                nleft = m_period;
                            end
                        end
                    end
                end
            endcase
            if (load) begin
                ncur = nq.pop_front();
                nperiod = (cfg_osr == 0) ? 1 : int'(cfg_osr);
                nleft = nperiod;
                ncnt = m_cnt + 16'd1;
                nmode = M_PLAY;
            end
            if (s_axis_tvalid && (mq.size() < DEPTH)) nq.push_back(s_axis_tdata);
        end
        nvalid = (nmode == M_PLAY) || (nmode == M_STARVED);
        if (nmode == M_PLAY) ndata = ncur;
        else if (nmode == M_STARVED) ndata = cfg_underrun_mute ? 16'h0000 : ncur;
        else ndata = 16'h0000;
        @(posedge aclk);
        #1;
        mq = nq;
        mode = nmode;
        m_period = nperiod;
        m_left = nleft;
        m_cur = ncur;
        m_cnt = ncnt;
        m_data = ndata;
        m_valid = nvalid;
        m_und = nund;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push(input logic [15:0] d);
        int guard;
        bit acc;
        guard = 0;
        acc = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata = d;
        while (!acc && guard < 300) begin
            acc = arst_n && cfg_enable && (mq.size() < DEPTH);
            step();
            guard++;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL push_timeout: sample %h not accepted, required acceptance within 300 cycles", d);
        end
    endtask

    // Monitor: per-cycle status against the model, ticks against the scoreboard
    always @(negedge aclk) begin
        if (mon_on) begin
            chk("m_tvalid", 32'(m_axis_tvalid), 32'(m_valid));
            chk("m_tdata", 32'(m_axis_tdata), 32'(m_data));
            chk("stat_underrun", 32'(stat_underrun), 32'(m_und));
            chk("fifo_level", 32'(stat_fifo_level), 32'(mq.size()));
            chk("s_tready", 32'(s_axis_tready), 32'(cfg_enable && (mq.size() < DEPTH)));
            chk("sample_cnt", 32'(stat_sample_cnt), 32'(m_cnt));
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tick_unexpected at %0t: got tick %h, required no tick", $time, m_axis_tdata);
                end else begin
                    chk("tick_data", 32'(m_axis_tdata), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        arst_n = 1'b0;
        cfg_enable = 1'b0;
        cfg_osr = 8'd4;
        cfg_underrun_mute = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata = '0;
        m_axis_tready = 1'b1;
        mode = M_OFF;
        m_cur = '0;
        m_data = '0;
        m_cnt = '0;
        m_period = 1;
        m_left = 0;
        m_valid = 1'b0;
        m_und = 1'b0;
        step();
        mon_on = 1'b1;
        step();

        // Reset/idle: disabled block refuses input
        arst_n = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata = 16'h1234;
        idle(3);
        s_axis_tvalid = 1'b0;

        // Basic hold, osr=4
        cfg_osr = 8'd4;
        cfg_enable = 1'b1;
        push(16'h1000);
        push(16'h2000);
        push(16'h3000);
        s_axis_tvalid = 1'b0;
        idle(14);
        cfg_enable = 1'b0;
        idle(2);

        // Underrun: repeat, then mute, then recovery at a period boundary
        cfg_enable = 1'b1;
        cfg_osr = 8'd2;
        cfg_underrun_mute = 1'b0;
        push(16'h7FFF);
        s_axis_tvalid = 1'b0;
        idle(7);
        cfg_underrun_mute = 1'b1;
        idle(4);
        cfg_underrun_mute = 1'b0;
        idle(1);
        push(16'h8000);
        s_axis_tvalid = 1'b0;
        idle(6);
        cfg_enable = 1'b0;
        idle(2);

        // Backpressure and full FIFO with toggling modulator ready
        cfg_enable = 1'b1;
        cfg_osr = 8'd8;
        for (int i = 0; i < 6; i++) push(16'(16'h0100 * (i + 1)));
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < 80; i++) begin
            m_axis_tready = 1'($urandom_range(0, 1));
            step();
        end
        m_axis_tready = 1'b1;
        cfg_enable = 1'b0;
        idle(2);

        // OSR change mid-sample, then osr=0
        cfg_enable = 1'b1;
        cfg_osr = 8'd3;
        push(16'hA001);
        push(16'hA002);
        s_axis_tvalid = 1'b0;
        idle(1);
        cfg_osr = 8'd5;
        idle(14);
        cfg_osr = 8'd0;
        push(16'hB001);
        push(16'hB002);
        push(16'hB003);
        s_axis_tvalid = 1'b0;
        idle(6);
        cfg_enable = 1'b0;
        idle(2);

        // Disable and reset mid-run with samples buffered
        cfg_enable = 1'b1;
        cfg_osr = 8'd8;
        for (int i = 0; i < 4; i++) push(16'(16'hC000 + i));
        s_axis_tvalid = 1'b0;
        idle(1);
        cfg_enable = 1'b0;
        idle(1);
        cfg_enable = 1'b1;
        idle(3);
        for (int i = 0; i < 4; i++) push(16'(16'hD000 + i));
        s_axis_tvalid = 1'b0;
        idle(1);
        arst_n = 1'b0;
        idle(1);
        arst_n = 1'b1;
        idle(3);
        push(16'hE001);
        s_axis_tvalid = 1'b0;
        idle(4);

        // Random traffic
        for (int seg = 0; seg < 60; seg++) begin
            int pv;
            int pr;
            cfg_osr = 8'($urandom_range(0, 9));
            cfg_underrun_mute = 1'($urandom_range(0, 1));
            pv = $urandom_range(5, 90);
            pr = $urandom_range(30, 100);
            for (int c = 0; c < 25; c++) begin
                arst_n = ($urandom_range(0, 299) != 0);
                cfg_enable = ($urandom_range(0, 99) != 0);
                s_axis_tvalid = ($urandom_range(0, 99) < pv);
                s_axis_tdata = 16'($urandom);
                m_axis_tready = ($urandom_range(0, 99) < pr);
                step();
            end
        end

        // Drain and close
        arst_n = 1'b1;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        cfg_enable = 1'b0;
        idle(3);
        @(negedge aclk);
        #1;
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dsm_dac_sample_scheduler.md
# dsm_dac_sample_scheduler

Rate-adapting front end for the first-order delta-sigma DAC stage. It accepts PCM samples on an AXI-Stream slave at the source rate and buffers them in a small FIFO. It presents each sample to the modulator for exactly `cfg_osr` accepted modulator ticks (zero-order hold), which sequences the DSM at its oversampled rate. Underrun, mute and enable/disable are handled here so the modulator always sees a continuous, well-defined input stream.

## Interface
- `WIDTH`, 16, PCM sample width (two's complement), equal to the modulator input width
- `OSR_W`, 8, width of the oversampling-ratio configuration
- `FIFO_DEPTH`, 4, input FIFO depth in samples (power of two, ≥2)

- `aclk`  in  1  clock
- `arst_n`  in  1  reset, synchronous, active-low
- `cfg_enable`  in  1  run control; 0 forces IDLE and flushes the FIFO
- `cfg_osr`  in  OSR_W  modulator ticks per sample; 0 treated as 1
- `cfg_underrun_mute`  in  1  on underrun: 1 = output zero, 0 = repeat last sample
- `s_axis_tdata`  in  WIDTH  input sample
- `s_axis_tvalid`  in  1  input valid
- `s_axis_tready`  out  1  input ready
- `m_axis_tdata`  out  WIDTH  sample to modulator (registered)
- `m_axis_tvalid`  out  1  modulator enable (registered)
- `m_axis_tready`  in  1  modulator ready; the tick is accepted when valid && ready
- `stat_underrun`  out  1  one-cycle pulse on entry to UNDERRUN
- `stat_fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- `stat_sample_cnt`  out  16  samples loaded from the FIFO; wraps at 2^16

## Operation
- Reset: state IDLE, FIFO empty, tick counter 0, hold register 0, all outputs 0.
- FIFO: `s_axis_tready = cfg_enable && !full`. A push occurs when tvalid && tready. A pop occurs only on a load event. Push and pop in the same cycle are legal, and the level is unchanged.
- Load event: pop the FIFO head into the hold register, latch `cfg_osr` (0→1) into `osr_q`, clear the tick counter and increment `stat_sample_cnt`.
- States:
  - IDLE: `m_axis_tvalid`=0, `m_axis_tdata`=0. If `cfg_enable`=1, go to PRIME.
  - PRIME: `m_axis_tvalid`=0. If the FIFO is non-empty, perform a load event and go to RUN.
  - RUN: `m_axis_tvalid`=1, `m_axis_tdata`=hold. Each accepted tick increments the counter.
    - On the accepted tick with counter = `osr_q`−1: if the FIFO is non-empty, perform a load event and stay in RUN.
    - Otherwise go to UNDERRUN and clear the counter.
  - UNDERRUN: `m_axis_tvalid`=1, `m_axis_tdata` = 0 if mute else hold.
    - The counter keeps running with period `osr_q`.
    - At each period end, if the FIFO is non-empty, perform a load event and go to RUN.
- `cfg_enable`=0 in any state: the next state is IDLE, the FIFO is flushed (level→0), the counter and hold register clear, and the outputs go to 0 on the following edge. This takes priority over every other transition.
- A `cfg_osr` change takes effect only at the next load event, never mid-sample.
- `m_axis_tready`=0 stalls the counter; `m_axis_tdata` stays stable.

## Timing
- Push at edge N: the FIFO is non-empty after edge N.
  - In PRIME, the load happens at edge N+1.
  - `m_axis_tvalid`=1 with the sample is visible after edge N+1.
- In RUN, with `m_axis_tready` held at 1, each sample occupies exactly `osr_q` consecutive cycles and the next sample appears without gaps.
- `stat_underrun` is high for the single cycle after the transition edge into UNDERRUN.
- The transition out of UNDERRUN happens only at a period boundary, never mid-period.
- Steady-state throughput: one sample per `osr_q` accepted ticks. No backpressure bubbles in `s_axis_tready` while the FIFO is not full.
- Reset mid-operation: all state and outputs return to reset values on the edge where `arst_n`=0 is sampled.

## Test plan
- Reset/idle:
  - Stimulus: `cfg_enable`=0, `s_axis_tvalid`=1.
  - Required: `s_axis_tready`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0, level=0.
- Basic hold:
  - Stimulus: osr=4, `m_axis_tready`=1; push 0x1000, 0x2000, 0x3000 back-to-back.
  - Required: `m_axis_tdata` = 0x1000×4, 0x2000×4, 0x3000×4 consecutive, first valid one cycle after the first push; `stat_sample_cnt`=3.
- Underrun:
  - Stimulus: osr=2, one sample 0x7FFF, mute=0.
  - Required: 0x7FFF for 2 cycles, then `stat_underrun` pulses once and 0x7FFF repeats; with mute=1 the output becomes 0x0000.
  - Follow-up: push 0x8000 mid-period. Required: it appears only at the next 2-cycle boundary.
- Backpressure and full:
  - Stimulus: osr=8, push 6 samples.
  - Required: `s_axis_tready` drops when the level reaches 4. Toggling `m_axis_tready` stretches each sample to exactly 8 accepted ticks.
- OSR change and zero:
  - Stimulus: change `cfg_osr` 3→5 mid-sample.
  - Required: the current sample lasts 3 ticks and the next lasts 5. With `cfg_osr`=0, each sample lasts 1 tick.
- Disable/reset mid-run:
  - Stimulus: drop `cfg_enable` with level=3 in RUN.
  - Required: the next cycle has IDLE outputs and level 0; re-enabling goes to PRIME. Repeat with `arst_n`=0; required: the same result.
